// File: rtl/ring_buffer.sv
// ---------------------------------------------------------------------------
// ring_buffer
//   Single-clock FIFO ring buffer that stages samples from the upstream PFB
//   stream for the UDP packetizer. Writes are stored in order. Each read pops
//   the oldest entry. Occupancy and the boundary flags are exported so that the
//   packetizer can frame datagrams.
//
// Parameters
//   N       data word width in bits
//   DEPTH   number of entries; must be a power of two
//   ADDR_W  pointer width, equal to $clog2(DEPTH)
//
// Ports
//   wclk          in   single clock; all logic updates on its rising edge
//   rst           in   synchronous, active-high reset
//   wr_en         in   write request
//   wr_data       in   write word
//   rd_en         in   read request
//   rd_valid      out  rd_data holds a word popped on the previous edge
//   rd_data       out  registered read word; holds its value when rd_valid=0
//   emptied       out  occupancy == 0
//   empty_next    out  occupancy == 1
//   filled        out  occupancy == DEPTH
//   full_next     out  occupancy == DEPTH-1
//   fill_counter  out  occupancy, 0..DEPTH
//
// Build option
//   RING_BUFFER_OVERWRITE_EN  When defined, a write while full and without a
//                             read is accepted. It replaces the oldest entry,
//                             so data is lost oldest-first. When undefined,
//                             such a write is dropped.
// ---------------------------------------------------------------------------
module ring_buffer #(
    parameter int N      = 8,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              wclk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [N-1:0]      wr_data,
    input  logic              rd_en,
    output logic              rd_valid,
    output logic [N-1:0]      rd_data,
    output logic              emptied,
    output logic              empty_next,
    output logic              filled,
    output logic              full_next,
    output logic [ADDR_W:0]   fill_counter
);

    localparam logic [ADDR_W:0]   CNT_ZERO    = '0;
    localparam logic [ADDR_W:0]   CNT_ONE     = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CNT_FULL    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_FULL_M1 = CNT_FULL - CNT_ONE;
    localparam logic [ADDR_W-1:0] PTR_ONE     = (ADDR_W)'(1);

    logic [N-1:0]      mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    logic              rd_acc;
    logic              wr_acc;
    logic              ovw;         // overwrite-while-full: advances both pointers
    logic [ADDR_W:0]   count_next;

    // Acceptance and next occupancy. The flags come from the registered count,
    // so these decisions always see a count and flags that agree.
    always_comb begin
        rd_acc = rd_en & ~emptied;
`ifdef RING_BUFFER_OVERWRITE_EN
        wr_acc = wr_en;
        ovw    = wr_en & filled & ~rd_acc;
`else
        wr_acc = wr_en & (~filled | rd_acc);
        ovw    = 1'b0;
`endif
        count_next = fill_counter;
        if (wr_acc && !rd_acc && !ovw) begin
            count_next = fill_counter + CNT_ONE;
        end else if (rd_acc && !wr_acc) begin
            count_next = fill_counter - CNT_ONE;
        end
    end

    // The storage has no reset, so RAM contents survive rst. Writes are gated
    // during reset because rst makes the request inputs be ignored.
    always_ff @(posedge wclk) begin
        if (wr_acc && !rst) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, read port and flags. A read from an address that is written on
    // the same edge (full with a simultaneous read and write) returns the old
    // word, which is the oldest entry.
    always_ff @(posedge wclk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fill_counter <= '0;
            emptied      <= 1'b1;
            empty_next   <= 1'b0;
            filled       <= 1'b0;
            full_next    <= 1'b0;
            rd_valid     <= 1'b0;
            rd_data      <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc || ovw) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            rd_valid <= rd_acc;
            if (rd_acc) begin
                rd_data <= mem[rd_ptr];
            end
            fill_counter <= count_next;
            emptied      <= (count_next == CNT_ZERO);
            empty_next   <= (count_next == CNT_ONE);
            filled       <= (count_next == CNT_FULL);
            full_next    <= (count_next == CNT_FULL_M1);
        end
    end

endmodule

// File: tb/tb_ring_buffer.sv
// ---------------------------------------------------------------------------
// tb_ring_buffer
//   Self-checking bench for ring_buffer. A queue-based reference model
//   predicts occupancy, flags and read data every cycle. The bench runs
//   directed reset, fill, overflow, drain, simultaneous and mid-stream reset
//   sequences, followed by biased random traffic.
//   Define RING_BUFFER_OVERWRITE_EN for both the bench and the RTL to check
//   the overwrite build.
// ---------------------------------------------------------------------------
module tb_ring_buffer;

    localparam int N      = 8;
    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 10;

    logic              wclk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic [N-1:0]      wr_data = '0;
    logic              rd_en = 1'b0;
    logic              rd_valid;
    logic [N-1:0]      rd_data;
    logic              emptied;
    logic              empty_next;
    logic              filled;
    logic              full_next;
    logic [ADDR_W:0]   fill_counter;

    ring_buffer #(.N(N), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .wclk         (wclk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .emptied      (emptied),
        .empty_next   (empty_next),
        .filled       (filled),
        .full_next    (full_next),
        .fill_counter (fill_counter)
    );

    always #5 wclk = ~wclk;

    int          checks = 0;
    int          errors = 0;

    // Reference model: stored words, oldest first.
    logic [N-1:0] q[$];
    logic         m_vld = 1'b0;
    logic [N-1:0] m_rd  = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic compare_all();
        int sz;
        sz = q.size();
        check("fill_counter", 32'(fill_counter), 32'(sz));
        check("emptied",      32'(emptied),      32'(sz == 0));
        check("empty_next",   32'(empty_next),   32'(sz == 1));
        check("filled",       32'(filled),       32'(sz == DEPTH));
        check("full_next",    32'(full_next),    32'(sz == DEPTH - 1));
        check("rd_valid",     32'(rd_valid),     32'(m_vld));
        check("rd_data",      32'(rd_data),      32'(m_rd));
    endtask

    // Apply one cycle of stimulus, advance the model, then sample 1 ns after
    // the edge.
    task automatic cycle(input logic r, input logic we, input logic [N-1:0] wd, input logic re);
        logic ra;
        logic wa;
        rst     = r;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        if (r) begin
            q.delete();
            m_vld = 1'b0;
            m_rd  = '0;
        end else begin
            ra = re && (q.size() > 0);
            wa = we && ((q.size() < DEPTH) || ra);
            m_vld = ra;
            if (ra) m_rd = q.pop_front();
            if (wa) begin
                q.push_back(wd);
            end
`ifdef RING_BUFFER_OVERWRITE_EN
            else if (we) begin
                void'(q.pop_front());
                q.push_back(wd);
            end
`endif
        end
        @(posedge wclk);
        #1;
        compare_all();
    endtask

    task automatic rand_phase(input int unsigned cycles, input int unsigned pw,
                              input int unsigned pr, input int unsigned prst);
        for (int unsigned i = 0; i < cycles; i++) begin
            cycle(($urandom_range(999) < prst) ? 1'b1 : 1'b0,
                  ($urandom_range(99) < pw) ? 1'b1 : 1'b0,
                  N'($urandom),
                  ($urandom_range(99) < pr) ? 1'b1 : 1'b0);
        end
    endtask

    initial begin
        // Reset for two cycles; the write request must be ignored.
        cycle(1'b1, 1'b1, 8'h5A, 1'b1);
        cycle(1'b1, 1'b1, 8'h5A, 1'b1);
        check("rst_emptied", 32'(emptied), 32'd1);
        check("rst_count",   32'(fill_counter), 32'd0);

        // Fill the buffer with 0..1023 (mod 256).
        for (int unsigned i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 1'b1, N'(i), 1'b0);
            if (i == DEPTH - 2) check("full_next_at_1023", 32'(full_next), 32'd1);
        end
        check("filled_at_1024", 32'(filled), 32'd1);
        check("count_at_1024",  32'(fill_counter), 32'd1024);

        // Write while full without a read.
        cycle(1'b0, 1'b1, 8'hAA, 1'b0);
        check("overflow_count", 32'(fill_counter), 32'd1024);

        // Drain, and run one extra cycle past empty.
        cycle(1'b0, 1'b0, '0, 1'b1);
`ifdef RING_BUFFER_OVERWRITE_EN
        check("first_read", 32'(rd_data), 32'h01);
`else
        check("first_read", 32'(rd_data), 32'h00);
`endif
        for (int unsigned i = 1; i <= DEPTH; i++) cycle(1'b0, 1'b0, '0, 1'b1);
        check("drain_emptied",  32'(emptied), 32'd1);
        check("drain_rd_valid", 32'(rd_valid), 32'd0);

        // Read and write on the same cycle while empty: only the write lands.
        cycle(1'b0, 1'b1, 8'h33, 1'b1);
        check("wr_rd_empty_count", 32'(fill_counter), 32'd1);
        check("wr_rd_empty_valid", 32'(rd_valid), 32'd0);

        // Simultaneous traffic at count=5.
        cycle(1'b1, 1'b0, '0, 1'b0);
        for (int unsigned i = 0; i < 5; i++) cycle(1'b0, 1'b1, N'(8'h10 + i), 1'b0);
        for (int unsigned i = 0; i < 10; i++) cycle(1'b0, 1'b1, N'(8'h20 + i), 1'b1);
        check("simul_count", 32'(fill_counter), 32'd5);

        // Reset in the middle of a stream.
        for (int unsigned i = 0; i < 100; i++) cycle(1'b0, 1'b1, N'($urandom), 1'b0);
        cycle(1'b1, 1'b1, 8'hEE, 1'b1);
        check("midrst_count",   32'(fill_counter), 32'd0);
        check("midrst_emptied", 32'(emptied), 32'd1);
        cycle(1'b0, 1'b0, '0, 1'b1);
        check("midrst_read_valid", 32'(rd_valid), 32'd0);

        // Biased random traffic that reaches full and empty, with rare resets.
        rand_phase(2000, 100, 20, 0);
        rand_phase(500,  50,  50, 0);
        rand_phase(1600, 10,  90, 0);
        rand_phase(1500, 60,  60, 2);
        rand_phase(1800, 95,  30, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
